// File: rtl/pmod_dac_wavegen.sv
// rtl/pmod_dac_wavegen.sv - waveform sequencer driving the PMOD DAC sample byte
//
// Purpose:
//    Generates saw-up, triangle, square and saw-down samples at a programmable
//    sample period. A debounced switch advances the waveform mode. Defining
//    WAVEGEN_NOISE_EN adds a fifth mode that plays a Galois LFSR.
//
// Ports:
//    i_Clk           system clock
//    i_Rst_L         asynchronous reset, active low
//    i_Enable        1 = run; 0 = freeze divider, phase and output
//    i_Mode_Next     debounced switch level; rising edge advances the mode
//    i_Div           sample period in clocks (0 behaves as 1)
//    o_Sample        current DAC sample, registered
//    o_Sample_Valid  one-cycle strobe when o_Sample updates
//    o_Mode          active mode index
//    o_Wrap          one-cycle strobe when the phase wraps to 0

module pmod_dac_wavegen #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic              i_Enable,
   input  logic              i_Mode_Next,
   input  logic [DIV_W-1:0]  i_Div,
   output logic [DATA_W-1:0] o_Sample,
   output logic              o_Sample_Valid,
   output logic [2:0]        o_Mode,
   output logic              o_Wrap
);

`ifdef WAVEGEN_NOISE_EN
   localparam int MODE_W = 3;
`else
   localparam int MODE_W = 2;
`endif

   localparam logic [MODE_W-1:0] MODE_SAW_UP   = MODE_W'(0);
   localparam logic [MODE_W-1:0] MODE_TRIANGLE = MODE_W'(1);
   localparam logic [MODE_W-1:0] MODE_SQUARE   = MODE_W'(2);
   localparam logic [MODE_W-1:0] MODE_SAW_DOWN = MODE_W'(3);
`ifdef WAVEGEN_NOISE_EN
   localparam logic [MODE_W-1:0] MODE_NOISE    = MODE_W'(4);
   localparam logic [MODE_W-1:0] MODE_LAST     = MODE_NOISE;
`else
   localparam logic [MODE_W-1:0] MODE_LAST     = MODE_SAW_DOWN;
`endif

   localparam logic [DATA_W-1:0] MAX = {DATA_W{1'b1}};

`ifdef WAVEGEN_NOISE_EN
   // Maximal-length Galois toggle masks, right-shifting form.
   localparam logic [15:0] TAPS_ALL =
      (DATA_W == 4)  ? 16'h000C : (DATA_W == 5)  ? 16'h0014 :
      (DATA_W == 6)  ? 16'h0030 : (DATA_W == 7)  ? 16'h0060 :
      (DATA_W == 8)  ? 16'h00B8 : (DATA_W == 9)  ? 16'h0110 :
      (DATA_W == 10) ? 16'h0240 : (DATA_W == 11) ? 16'h0500 :
      (DATA_W == 12) ? 16'h0829 : (DATA_W == 13) ? 16'h100D :
      (DATA_W == 14) ? 16'h2015 : (DATA_W == 15) ? 16'h6000 : 16'hD008;
   localparam logic [DATA_W-1:0] LFSR_TAPS = TAPS_ALL[DATA_W-1:0];
   localparam logic [DATA_W-1:0] LFSR_SEED = '1;
`endif

   typedef enum logic {DIR_UP, DIR_DN} dir_e;

   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [DATA_W-1:0] phase_q, phase_d;
   logic [DATA_W-1:0] sample_q, sample_d;
   logic              valid_q, valid_d;
   logic              wrap_q, wrap_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   dir_e              dir_q, dir_d;
   logic [1:0]        mode_sync_q, mode_sync_d;
   logic [1:0]        hist_vld_q, hist_vld_d;
`ifdef WAVEGEN_NOISE_EN
   logic [DATA_W-1:0] lfsr_q, lfsr_d, lfsr_step;
`endif

   logic [DIV_W-1:0]  div_max;
   logic              tick;
   logic              mode_edge;
   logic [DATA_W-1:0] phase_inc;

   always_comb begin
      div_max     = (i_Div == '0) ? DIV_W'(1) : i_Div;
      // ">=" rather than "==" so a period shortened mid-count ticks at once.
      tick        = i_Enable && (div_cnt_q >= div_max - DIV_W'(1));
      // Edges only count once both history flops hold real switch samples,
      // so a switch already high when reset releases is not an edge.
      mode_edge   = hist_vld_q[1] && mode_sync_q[0] && !mode_sync_q[1];
      phase_inc   = phase_q + DATA_W'(1);
      mode_sync_d = {mode_sync_q[0], i_Mode_Next};
      hist_vld_d  = {hist_vld_q[0], 1'b1};

      div_cnt_d = div_cnt_q;
      phase_d   = phase_q;
      sample_d  = sample_q;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
      mode_d    = mode_q;
      dir_d     = dir_q;
`ifdef WAVEGEN_NOISE_EN
      lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
      lfsr_d    = lfsr_q;
`endif

      if (mode_edge) begin
         // Mode change takes priority over a coincident tick.
         mode_d    = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
         phase_d   = '0;
         div_cnt_d = '0;
         dir_d     = DIR_UP;
         sample_d  = '0;
         valid_d   = 1'b1;
`ifdef WAVEGEN_NOISE_EN
         if (mode_d == MODE_NOISE) begin
            lfsr_d = LFSR_SEED;
         end
`endif
      end else if (tick) begin
         div_cnt_d = '0;
         phase_d   = phase_inc;
         wrap_d    = (phase_q == MAX);
         valid_d   = 1'b1;
`ifdef WAVEGEN_NOISE_EN
         lfsr_d    = lfsr_step;
`endif
         case (mode_q)
            MODE_SAW_UP: sample_d = phase_inc;
            MODE_TRIANGLE: begin
               // Steps from the last sample; the peak and trough are emitted once.
               if (dir_q == DIR_UP) begin
                  if (sample_q == MAX) begin
                     sample_d = MAX - DATA_W'(1);
                     dir_d    = DIR_DN;
                  end else begin
                     sample_d = sample_q + DATA_W'(1);
                  end
               end else begin
                  if (sample_q == '0) begin
                     sample_d = DATA_W'(1);
                     dir_d    = DIR_UP;
                  end else begin
                     sample_d = sample_q - DATA_W'(1);
                  end
               end
            end
            MODE_SQUARE:   sample_d = phase_inc[DATA_W-1] ? MAX : '0;
            MODE_SAW_DOWN: sample_d = MAX - phase_inc;
`ifdef WAVEGEN_NOISE_EN
            MODE_NOISE:    sample_d = lfsr_step;
`endif
            default:       sample_d = '0;
         endcase
      end else if (i_Enable) begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         div_cnt_q   <= '0;
         phase_q     <= '0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         wrap_q      <= 1'b0;
         mode_q      <= '0;
         dir_q       <= DIR_UP;
         mode_sync_q <= '0;
         hist_vld_q  <= '0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         phase_q     <= phase_d;
         sample_q    <= sample_d;
         valid_q     <= valid_d;
         wrap_q      <= wrap_d;
         mode_q      <= mode_d;
         dir_q       <= dir_d;
         mode_sync_q <= mode_sync_d;
         hist_vld_q  <= hist_vld_d;
      end
   end

`ifdef WAVEGEN_NOISE_EN
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign o_Mode = mode_q;
`else
   assign o_Mode = {1'b0, mode_q};
`endif

   assign o_Sample       = sample_q;
   assign o_Sample_Valid = valid_q;
   assign o_Wrap         = wrap_q;

endmodule
